// File: rtl/decode_issue_reg.sv
// Decode-to-execute issue register: resolves source operands, latches the decode
// instruction into execute under valid/ready, inserts bubbles on hazards, counts stalls.
module decode_issue_reg #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             valid_D,
    output logic             ready_D,
    input  logic             flush_D,
    input  logic             stall_D,
    input  logic [31:0]      pc_D,
    input  logic [31:0]      imm_D,
    input  logic [4:0]       type_D,
    input  logic [15:0]      ctrl_D,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_D,
    input  logic [31:0]      rdata1_D,
    input  logic [31:0]      rdata2_D,
    input  logic [31:0]      forward_rs1,
    input  logic [31:0]      forward_rs2,
    input  logic             valid_forward_rs1,
    input  logic             valid_forward_rs2,

    output logic             valid_E,
    input  logic             ready_E,
    output logic [31:0]      pc_E,
    output logic [31:0]      imm_E,
    output logic [31:0]      src1_E,
    output logic [31:0]      src2_E,
    output logic [4:0]       type_E,
    output logic [15:0]      ctrl_E,
    output logic [4:0]       rd_E,
    output logic             load_E,

    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cycles
);

    // x0 always reads zero; otherwise a valid forward beats the register file.
    function automatic logic [31:0] resolve_operand(
        input logic [4:0]  idx,
        input logic        fwd_valid,
        input logic [31:0] fwd_value,
        input logic [31:0] rf_value
    );
        if (idx == 5'd0)
            return 32'd0;
        else if (fwd_valid)
            return fwd_value;
        else
            return rf_value;
    endfunction

    logic             w_advance;
    logic             w_load;
    logic             w_stall_inc;
    logic             w_bubble_inc;
    logic [31:0]      w_src1;
    logic [31:0]      w_src2;

    logic             r_valid_E;
    logic [31:0]      r_pc_E;
    logic [31:0]      r_imm_E;
    logic [31:0]      r_src1_E;
    logic [31:0]      r_src2_E;
    logic [4:0]       r_type_E;
    logic [15:0]      r_ctrl_E;
    logic [4:0]       r_rd_E;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_cycles;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_src1 = resolve_operand(rs1_D, valid_forward_rs1, forward_rs1, rdata1_D);
        w_src2 = resolve_operand(rs2_D, valid_forward_rs2, forward_rs2, rdata2_D);
    end

    assign w_advance    = ~r_valid_E | ready_E;
    assign w_load       = valid_D & ~stall_D & ~flush_D;
    assign w_stall_inc  = valid_D & stall_D & ~flush_D;
    // Only hazard/flush bubbles count; an empty decode stage is not a lost slot.
    assign w_bubble_inc = w_advance & ~w_load & valid_D;

    // A flushed instruction is always drained, even while execute is blocked.
    assign ready_D = ~rst & (flush_D | (w_advance & ~stall_D));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_E <= 1'b0;
            r_pc_E    <= '0;
            r_imm_E   <= '0;
            r_src1_E  <= '0;
            r_src2_E  <= '0;
            r_type_E  <= '0;
            r_ctrl_E  <= '0;
            r_rd_E    <= '0;
        end else if (w_advance) begin
            if (w_load) begin
                r_valid_E <= 1'b1;
                r_pc_E    <= pc_D;
                r_imm_E   <= imm_D;
                r_src1_E  <= w_src1;
                r_src2_E  <= w_src2;
                r_type_E  <= type_D;
                r_ctrl_E  <= ctrl_D;
                r_rd_E    <= rd_D;
            end else begin
                // Bubble: clear destination and format so the hazard unit sees nothing.
                r_valid_E <= 1'b0;
                r_type_E  <= '0;
                r_rd_E    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else if (cnt_clr) begin
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            if (w_stall_inc)
                r_stall_cycles  <= r_stall_cycles + CNT_W'(1);
            if (w_bubble_inc)
                r_bubble_cycles <= r_bubble_cycles + CNT_W'(1);
        end
    end

    assign valid_E       = r_valid_E;
    assign pc_E          = r_pc_E;
    assign imm_E         = r_imm_E;
    assign src1_E        = r_src1_E;
    assign src2_E        = r_src2_E;
    assign type_E        = r_type_E;
    assign ctrl_E        = r_ctrl_E;
    assign rd_E          = r_rd_E;
    assign load_E        = r_ctrl_E[0];
    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;

endmodule

// File: tb/tb_decode_issue_reg.sv
// Directed bench for decode_issue_reg: vector table for issue/stall/backpressure/flush,
// hand sequences for reset, counter wrap (narrow-counter twin) and cnt_clr.
module tb_decode_issue_reg;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [4:0] TYPE_R = 5'b00001;

    logic        clk;
    logic        rst;
    logic        valid_D, ready_D, flush_D, stall_D;
    logic [31:0] pc_D, imm_D;
    logic [4:0]  type_D;
    logic [15:0] ctrl_D;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic [31:0] rdata1_D, rdata2_D, forward_rs1, forward_rs2;
    logic        valid_forward_rs1, valid_forward_rs2;
    logic        valid_E, ready_E;
    logic [31:0] pc_E, imm_E, src1_E, src2_E;
    logic [4:0]  type_E, rd_E;
    logic [15:0] ctrl_E;
    logic        load_E;
    logic        cnt_clr;
    logic [31:0] stall_cycles, bubble_cycles;

    // Twin with 3-bit counters, sharing all inputs, to observe counter wrap.
    logic        s_ready_D, s_valid_E, s_load_E;
    logic [31:0] s_pc_E, s_imm_E, s_src1_E, s_src2_E;
    logic [4:0]  s_type_E, s_rd_E;
    logic [15:0] s_ctrl_E;
    logic [2:0]  s_stall_cycles, s_bubble_cycles;

    int n_checks = 0;
    int n_errors = 0;

    decode_issue_reg #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .valid_D(valid_D), .ready_D(ready_D), .flush_D(flush_D), .stall_D(stall_D),
        .pc_D(pc_D), .imm_D(imm_D), .type_D(type_D), .ctrl_D(ctrl_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .rdata1_D(rdata1_D), .rdata2_D(rdata2_D),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .valid_forward_rs1(valid_forward_rs1), .valid_forward_rs2(valid_forward_rs2),
        .valid_E(valid_E), .ready_E(ready_E),
        .pc_E(pc_E), .imm_E(imm_E), .src1_E(src1_E), .src2_E(src2_E),
        .type_E(type_E), .ctrl_E(ctrl_E), .rd_E(rd_E), .load_E(load_E),
        .cnt_clr(cnt_clr), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
    );

    decode_issue_reg #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst),
        .valid_D(valid_D), .ready_D(s_ready_D), .flush_D(flush_D), .stall_D(stall_D),
        .pc_D(pc_D), .imm_D(imm_D), .type_D(type_D), .ctrl_D(ctrl_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .rdata1_D(rdata1_D), .rdata2_D(rdata2_D),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .valid_forward_rs1(valid_forward_rs1), .valid_forward_rs2(valid_forward_rs2),
        .valid_E(s_valid_E), .ready_E(ready_E),
        .pc_E(s_pc_E), .imm_E(s_imm_E), .src1_E(s_src1_E), .src2_E(s_src2_E),
        .type_E(s_type_E), .ctrl_E(s_ctrl_E), .rd_E(s_rd_E), .load_E(s_load_E),
        .cnt_clr(cnt_clr), .stall_cycles(s_stall_cycles), .bubble_cycles(s_bubble_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vd, st, fl, re;
        logic [31:0] pc;
        logic [4:0]  r1;
        logic [31:0] rd1;
        logic        v1;
        logic [31:0] f1;
        logic [4:0]  r2;
        logic [31:0] rd2;
        logic        v2;
        logic [31:0] f2;
        logic [4:0]  rd;
        logic        x_rdy, x_val;
        logic [31:0] x_pc, x_s1, x_s2;
        logic [4:0]  x_rd;
        logic [31:0] x_stall, x_bubble;
    } vec_t;

    function automatic vec_t mk(
        input logic vd, input logic st, input logic fl, input logic re,
        input logic [31:0] pc,
        input logic [4:0] r1, input logic [31:0] rd1, input logic v1, input logic [31:0] f1,
        input logic [4:0] r2, input logic [31:0] rd2, input logic v2, input logic [31:0] f2,
        input logic [4:0] rd,
        input logic x_rdy, input logic x_val, input logic [31:0] x_pc,
        input logic [31:0] x_s1, input logic [31:0] x_s2, input logic [4:0] x_rd,
        input logic [31:0] x_stall, input logic [31:0] x_bubble
    );
        vec_t v;
        v.vd = vd; v.st = st; v.fl = fl; v.re = re; v.pc = pc;
        v.r1 = r1; v.rd1 = rd1; v.v1 = v1; v.f1 = f1;
        v.r2 = r2; v.rd2 = rd2; v.v2 = v2; v.f2 = f2; v.rd = rd;
        v.x_rdy = x_rdy; v.x_val = x_val; v.x_pc = x_pc;
        v.x_s1 = x_s1; v.x_s2 = x_s2; v.x_rd = x_rd;
        v.x_stall = x_stall; v.x_bubble = x_bubble;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        valid_D = L; stall_D = L; flush_D = L; ready_E = H; cnt_clr = L;
        pc_D = 32'h0; imm_D = 32'h0; type_D = TYPE_R; ctrl_D = 16'h0;
        rs1_D = 5'd0; rs2_D = 5'd0; rd_D = 5'd0;
        rdata1_D = 32'h0; rdata2_D = 32'h0; forward_rs1 = 32'h0; forward_rs2 = 32'h0;
        valid_forward_rs1 = L; valid_forward_rs2 = L;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int i);
        logic [31:0] x_imm;
        logic [15:0] x_ctrl;
        valid_D = v.vd; stall_D = v.st; flush_D = v.fl; ready_E = v.re;
        pc_D = v.pc; imm_D = ~v.pc; ctrl_D = v.pc[17:2]; type_D = TYPE_R;
        rs1_D = v.r1; rdata1_D = v.rd1; valid_forward_rs1 = v.v1; forward_rs1 = v.f1;
        rs2_D = v.r2; rdata2_D = v.rd2; valid_forward_rs2 = v.v2; forward_rs2 = v.f2;
        rd_D = v.rd;
        #2;
        check($sformatf("r%0d ready_D", i), 32'(ready_D), 32'(v.x_rdy));
        step();
        x_imm  = ~v.x_pc;
        x_ctrl = v.x_pc[17:2];
        check($sformatf("r%0d valid_E", i), 32'(valid_E), 32'(v.x_val));
        check($sformatf("r%0d pc_E", i), pc_E, v.x_pc);
        check($sformatf("r%0d imm_E", i), imm_E, x_imm);
        check($sformatf("r%0d ctrl_E", i), 32'(ctrl_E), 32'(x_ctrl));
        check($sformatf("r%0d load_E", i), 32'(load_E), 32'(v.x_pc[2]));
        check($sformatf("r%0d type_E", i), 32'(type_E), v.x_val ? 32'(TYPE_R) : 32'd0);
        check($sformatf("r%0d src1_E", i), src1_E, v.x_s1);
        check($sformatf("r%0d src2_E", i), src2_E, v.x_s2);
        check($sformatf("r%0d rd_E", i), 32'(rd_E), 32'(v.x_rd));
        check($sformatf("r%0d stall_cycles", i), stall_cycles, v.x_stall);
        check($sformatf("r%0d bubble_cycles", i), bubble_cycles, v.x_bubble);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, " valid_E"}, 32'(valid_E), 32'd0);
        check({tag, " pc_E"}, pc_E, 32'd0);
        check({tag, " imm_E"}, imm_E, 32'd0);
        check({tag, " src1_E"}, src1_E, 32'd0);
        check({tag, " src2_E"}, src2_E, 32'd0);
        check({tag, " type_E"}, 32'(type_E), 32'd0);
        check({tag, " ctrl_E"}, 32'(ctrl_E), 32'd0);
        check({tag, " rd_E"}, 32'(rd_E), 32'd0);
        check({tag, " load_E"}, 32'(load_E), 32'd0);
        check({tag, " stall_cycles"}, stall_cycles, 32'd0);
        check({tag, " bubble_cycles"}, bubble_cycles, 32'd0);
    endtask

    vec_t vecs[17];

    initial begin
        //                vd st fl re  pc          r1    rd1          v1 f1            r2    rd2          v2 f2           rd     rdy val x_pc         x_s1          x_s2          x_rd   stall   bubble
        vecs[0]  = mk(H, L, L, H, 32'h100, 5'd1, 32'h1001, L, 32'h0,    5'd2, 32'h2001, L, 32'h0,    5'd3,  H, H, 32'h100, 32'h1001, 32'h2001, 5'd3,  32'd0, 32'd0);
        vecs[1]  = mk(H, L, L, H, 32'h104, 5'd1, 32'h1002, L, 32'h0,    5'd2, 32'h2002, L, 32'h0,    5'd3,  H, H, 32'h104, 32'h1002, 32'h2002, 5'd3,  32'd0, 32'd0);
        vecs[2]  = mk(H, L, L, H, 32'h108, 5'd1, 32'h1003, L, 32'h0,    5'd2, 32'h2003, L, 32'h0,    5'd3,  H, H, 32'h108, 32'h1003, 32'h2003, 5'd3,  32'd0, 32'd0);
        vecs[3]  = mk(H, L, L, H, 32'h10C, 5'd1, 32'h1004, L, 32'h0,    5'd2, 32'h2004, L, 32'h0,    5'd3,  H, H, 32'h10C, 32'h1004, 32'h2004, 5'd3,  32'd0, 32'd0);
        // Forward select, then x0 overriding a valid forward.
        vecs[4]  = mk(H, L, L, H, 32'h110, 5'd5, 32'h11,   H, 32'hDEAD, 5'd7, 32'h22,   H, 32'hBEEF, 5'd4,  H, H, 32'h110, 32'hDEAD, 32'hBEEF, 5'd4,  32'd0, 32'd0);
        vecs[5]  = mk(H, L, L, H, 32'h114, 5'd0, 32'h11,   H, 32'hDEAD, 5'd0, 32'h22,   H, 32'hBEEF, 5'd4,  H, H, 32'h114, 32'h0,    32'h0,    5'd4,  32'd0, 32'd0);
        // Load-use stall: bubble, then issue with the operand from the clearing cycle.
        vecs[6]  = mk(H, H, L, H, 32'h118, 5'd1, 32'h1005, L, 32'h0,    5'd6, 32'h66,   H, 32'h33,   5'd5,  L, L, 32'h114, 32'h0,    32'h0,    5'd0,  32'd1, 32'd1);
        vecs[7]  = mk(H, L, L, H, 32'h118, 5'd1, 32'h1005, L, 32'h0,    5'd6, 32'h66,   H, 32'h55,   5'd5,  H, H, 32'h118, 32'h1005, 32'h55,   5'd5,  32'd1, 32'd1);
        // Backpressure for 3 cycles while decode changes, then release.
        vecs[8]  = mk(H, L, L, L, 32'h11C, 5'd1, 32'h1006, L, 32'h0,    5'd2, 32'h2006, L, 32'h0,    5'd6,  L, H, 32'h118, 32'h1005, 32'h55,   5'd5,  32'd1, 32'd1);
        vecs[9]  = mk(H, L, L, L, 32'h120, 5'd1, 32'h1007, L, 32'h0,    5'd2, 32'h2007, L, 32'h0,    5'd7,  L, H, 32'h118, 32'h1005, 32'h55,   5'd5,  32'd1, 32'd1);
        vecs[10] = mk(H, L, L, L, 32'h124, 5'd1, 32'h1008, L, 32'h0,    5'd2, 32'h2008, L, 32'h0,    5'd8,  L, H, 32'h118, 32'h1005, 32'h55,   5'd5,  32'd1, 32'd1);
        vecs[11] = mk(H, L, L, H, 32'h128, 5'd1, 32'h1007, L, 32'h0,    5'd2, 32'h2007, L, 32'h0,    5'd7,  H, H, 32'h128, 32'h1007, 32'h2007, 5'd7,  32'd1, 32'd1);
        // Flush with stall while advancing: bubble, stall counter untouched.
        vecs[12] = mk(H, H, H, H, 32'h12C, 5'd1, 32'h1008, L, 32'h0,    5'd2, 32'h2008, L, 32'h0,    5'd8,  H, L, 32'h128, 32'h1007, 32'h2007, 5'd0,  32'd1, 32'd2);
        vecs[13] = mk(H, L, L, H, 32'h130, 5'd1, 32'h1009, L, 32'h0,    5'd2, 32'h2009, L, 32'h0,    5'd9,  H, H, 32'h130, 32'h1009, 32'h2009, 5'd9,  32'd1, 32'd2);
        // Flush with stall under backpressure: execute keeps its instruction.
        vecs[14] = mk(H, H, H, L, 32'h134, 5'd1, 32'h100A, L, 32'h0,    5'd2, 32'h200A, L, 32'h0,    5'd10, H, H, 32'h130, 32'h1009, 32'h2009, 5'd9,  32'd1, 32'd2);
        // Empty decode: bubble without counting; stall without valid_D counts nothing.
        vecs[15] = mk(L, L, L, H, 32'h138, 5'd1, 32'h100B, L, 32'h0,    5'd2, 32'h200B, L, 32'h0,    5'd11, H, L, 32'h130, 32'h1009, 32'h2009, 5'd0,  32'd1, 32'd2);
        vecs[16] = mk(L, H, L, H, 32'h13C, 5'd1, 32'h100C, L, 32'h0,    5'd2, 32'h200C, L, 32'h0,    5'd12, L, L, 32'h130, 32'h1009, 32'h2009, 5'd0,  32'd1, 32'd2);

        // Reset with decode active: ready_D low, everything cleared.
        drive_idle();
        rst = H; valid_D = H; pc_D = 32'h55; rs1_D = 5'd1; rdata1_D = 32'h77; rd_D = 5'd3;
        #2;
        check("reset ready_D", 32'(ready_D), 32'd0);
        step();
        check_all_reset("reset");
        step();
        rst = L;
        drive_idle();

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], i);
            check($sformatf("r%0d small stall_cycles", i), 32'(s_stall_cycles), 32'(vecs[i].x_stall[2:0]));
        end

        // Counter wrap: seven more stall cycles take the 3-bit twin from 1 to 0.
        drive_idle();
        valid_D = H; stall_D = H; pc_D = 32'h140; rd_D = 5'd1;
        #2;
        check("wrap ready_D", 32'(ready_D), 32'd0);
        for (int k = 0; k < 7; k++) step();
        check("wrap stall_cycles", stall_cycles, 32'd8);
        check("wrap bubble_cycles", bubble_cycles, 32'd9);
        check("wrap small stall_cycles", 32'(s_stall_cycles), 32'd0);
        check("wrap small bubble_cycles", 32'(s_bubble_cycles), 32'd1);

        // cnt_clr beats the increments of the same cycle.
        cnt_clr = H;
        step();
        check("clr stall_cycles", stall_cycles, 32'd0);
        check("clr bubble_cycles", bubble_cycles, 32'd0);
        check("clr small stall_cycles", 32'(s_stall_cycles), 32'd0);
        cnt_clr = L;
        step();
        check("post-clr stall_cycles", stall_cycles, 32'd1);
        check("post-clr bubble_cycles", bubble_cycles, 32'd1);

        // Mid-stream reset drops a held instruction.
        stall_D = L; pc_D = 32'h200; imm_D = 32'hABCD; ctrl_D = 16'h0001; rd_D = 5'd5;
        rs1_D = 5'd3; rdata1_D = 32'h3333;
        step();
        check("pre-rst valid_E", 32'(valid_E), 32'd1);
        check("pre-rst load_E", 32'(load_E), 32'd1);
        check("pre-rst src1_E", src1_E, 32'h3333);
        rst = H; ready_E = L; flush_D = H; stall_D = H; cnt_clr = H;
        #2;
        check("mid-rst ready_D", 32'(ready_D), 32'd0);
        step();
        check_all_reset("mid-rst");
        check("mid-rst small stall_cycles", 32'(s_stall_cycles), 32'd0);
        rst = L;
        drive_idle();
        step();
        check("post-rst valid_E", 32'(valid_E), 32'd0);
        check("post-rst bubble_cycles", bubble_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
